uart_tx_arbiter: RTL

- Shares one UART transmit byte channel between `num_req` packet sources.
- Arbitration is round-robin at packet granularity: once a source is granted, it holds the channel until it sends a byte flagged last, or until the packet hits the length cap.
- Sits between message producers (debug console, status reporter, loopback echo of the rx path, ...) and the single transmitter's valid/ready byte input.
- Output is registered: one-entry output buffer.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Start + 8 data + stop: line time of one byte in bit periods.
    localparam int bits_per_byte = 10;

    // Upper bound on requesters; grant and round-robin indices are 3 bits wide.
    localparam int max_req = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side byte channels of the arbiter.
//
// Handshake: on every channel a byte moves at a rising clock edge where its
// valid and ready are both high. A source keeps its byte and last flag stable
// while valid is high and ready is low; ready never waits for valid.
interface uart_tx_arbiter_if #(
    parameter int num_req = 4
);
    import uart_pkg::*;

    logic [num_req-1:0][7:0] _in_data;
    logic [num_req-1:0]      _in_valid;
    logic [num_req-1:0]      _in_last;
    logic [num_req-1:0]      _in_ready;
    byte_t                   _out;
    logic                    _out_valid;
    logic                    _out_ready;
    logic [2:0]              _grant;
    logic                    _busy;
    logic                    _trunc;
    arb_state_t              _dbg_state;

    modport master (
        output _in_data, _in_valid, _in_last, _out_ready,
        input  _in_ready, _out, _out_valid, _grant, _busy, _trunc, _dbg_state
    );

    modport slave (
        input  _in_data, _in_valid, _in_last, _out_ready,
        output _in_ready, _out, _out_valid, _grant, _busy, _trunc, _dbg_state
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search, starting just after `last`.
module rr_pick
    import uart_pkg::*;
#(
    parameter int num_req = 4
) (
    input  logic [num_req-1:0] req,
    input  logic [2:0]         last,
    output logic [2:0]         winner,
    output logic               any_req
);

    logic [max_req-1:0] req_pad;
    logic [2:0]         idx;

    assign req_pad = max_req'(req);
    assign any_req = |req;

    // Scan from the farthest position inward so the nearest request after `last` wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = num_req; k >= 1; k--) begin
            idx = 3'((int'(last) + k) % num_req);
            if (req_pad[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX byte channel,
// with a one-entry registered output buffer and a per-grant length cap.
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant whose owner
// stays silent for timeout_cycles cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int num_req        = 4,
    parameter int max_packet     = 64,
    parameter int timeout_cycles = 255
) (
    input  logic             _clock,
    input  logic             _reset_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int cnt_w = $clog2(max_packet + 1);

    // Reject configurations the 3-bit indices and counters cannot represent.
    if (num_req < 2 || num_req > max_req || max_packet < 1 || timeout_cycles < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported configuration");
    end

    arb_state_t                 state, state_nxt;
    logic [2:0]                 last, grant, winner;
    logic                       any_req;
    logic [cnt_w-1:0]           count;
    logic [max_req-1:0]         valid_pad, last_pad;
    logic [max_req-1:0][7:0]    data_pad;
    logic                       g_valid, g_last, buf_free, accept, cap_hit, pkt_end, timeout_hit;
    byte_t                      g_data;

    assign valid_pad = max_req'(bus._in_valid);
    assign last_pad  = max_req'(bus._in_last);
    assign data_pad  = (max_req * 8)'(bus._in_data);

    assign g_valid  = valid_pad[grant];
    assign g_last   = last_pad[grant];
    assign g_data   = data_pad[grant];
    assign buf_free = !bus._out_valid || bus._out_ready;
    assign accept   = (state == XFER) && g_valid && buf_free;
    assign cap_hit  = (count == cnt_w'(max_packet - 1));
    assign pkt_end  = accept && (g_last || cap_hit);

    rr_pick #(.num_req(num_req)) u_pick (
        .req     (bus._in_valid),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int idle_w = $clog2(timeout_cycles + 1);
    logic [idle_w-1:0] idle_cnt;

    // Count consecutive granted cycles with no byte offered by the owner.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            idle_cnt <= '0;
        end else if (state != XFER || g_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == XFER) && !g_valid && (idle_cnt == idle_w'(timeout_cycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, hold the grant until the packet ends or is revoked.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = XFER;
            XFER:    if (pkt_end || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: only the owner sees ready, and only when the buffer can take a byte.
    always_comb begin
        bus._in_ready  = '0;
        bus._busy      = (state == XFER);
        bus._dbg_state = state;
        bus._grant     = grant;
        for (int i = 0; i < num_req; i++) begin
            bus._in_ready[i] = (state == XFER) && (grant == 3'(i)) && buf_free;
        end
    end

    // Grant, fairness pointer and per-grant byte count.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            grant <= '0;
            last  <= 3'(num_req - 1);
            count <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                grant <= winner;
                count <= '0;
            end
        end else begin
            if (pkt_end || timeout_hit) begin
                last <= grant;
            end
            if (accept) begin
                count <= count + 1'b1;
            end
        end
    end

    // One-entry output buffer plus the truncation pulse; the buffer drains in either state.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            bus._out       <= '0;
            bus._out_valid <= 1'b0;
            bus._trunc     <= 1'b0;
        end else begin
            bus._trunc <= (pkt_end && !g_last) || timeout_hit;
            if (accept) begin
                bus._out       <= g_data;
                bus._out_valid <= 1'b1;
            end else if (bus._out_ready) begin
                bus._out_valid <= 1'b0;
            end
        end
    end

endmodule
